imm_field_packer: RTL

- Inverse of the sign-extension path: takes a 64-bit immediate and a base instruction word, packs the immediate into the field selected by Ctrl, and range-checks it.
- Sits in the instruction loader/patch path ahead of instruction memory. Used for relocation and branch-offset fix-up of LEGv8 words.
- Two-stage valid/ready pipeline with a saturating error counter.
- Field encoding matches the decode side exactly, so extending a packed word returns the original immediate whenever OutErr=0.

---
 rtl/imm_field_packer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imm_field_packer.sv
// imm_field_packer
//   Packs a 64-bit immediate into the I, D, B or CB field of a LEGv8 instruction word and flags
//   immediates that do not fit the selected field. Two-stage valid/ready pipeline. Errored
//   results are counted in a saturating counter.
//
// Ports
//   CLK, Reset_n        clock (rising edge), asynchronous active-low reset
//   InValid / InReady   request handshake
//   InInst, InImm       base instruction word and immediate to encode
//   InCtrl              field select: 00 I, 01 D, 10 B, 11 CB
//   OutValid / OutReady result handshake
//   OutInst, OutErr     packed word, immediate-out-of-range flag
//   ErrCount            number of errored results accepted downstream (saturating)
//   ErrClr              synchronous clear of ErrCount; wins over a same-cycle increment

module imm_field_packer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      InInst,
  input  logic [63:0]      InImm,
  input  logic [1:0]       InCtrl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [31:0]      OutInst,
  output logic             OutErr,
  output logic [CNT_W-1:0] ErrCount,
  input  logic             ErrClr
);

  typedef enum logic [1:0] {
    FieldI  = 2'b00,
    FieldD  = 2'b01,
    FieldB  = 2'b10,
    FieldCb = 2'b11
  } field_e;

  // Stage 1: registered request
  logic        s1_valid_q;
  logic [31:0] s1_inst_q;
  logic [63:0] s1_imm_q;
  field_e      s1_ctrl_q;

  // Stage 2: registered result
  logic        s2_valid_q;
  logic [31:0] s2_inst_q;
  logic        s2_err_q;

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        adv2;
  logic        out_xfer;
  logic [31:0] pack_inst;
  logic        pack_err;

  assign adv2     = !s2_valid_q || OutReady;
  assign InReady  = !s1_valid_q || adv2;
  assign out_xfer = s2_valid_q && OutReady;

  assign OutValid = s2_valid_q;
  assign OutInst  = s2_inst_q;
  assign OutErr   = s2_err_q;
  assign ErrCount = err_cnt_q;

  // Field insertion and range check. Signed fields fit when every bit from the field's sign
  // bit upward is identical; the I field is unsigned so all bits above it must be zero.
  always_comb begin
    pack_inst = s1_inst_q;
    pack_err  = 1'b0;
    case (s1_ctrl_q)
      FieldI: begin
        pack_inst[21:10] = s1_imm_q[11:0];
        pack_err         = |s1_imm_q[63:12];
      end
      FieldD: begin
        pack_inst[20:12] = s1_imm_q[8:0];
        pack_err         = !((&s1_imm_q[63:8]) || !(|s1_imm_q[63:8]));
      end
      FieldB: begin
        pack_inst[25:0] = s1_imm_q[25:0];
        pack_err        = !((&s1_imm_q[63:25]) || !(|s1_imm_q[63:25]));
      end
      FieldCb: begin
        pack_inst[23:5] = s1_imm_q[18:0];
        pack_err        = !((&s1_imm_q[63:18]) || !(|s1_imm_q[63:18]));
      end
      default: begin
        pack_inst = s1_inst_q;
        pack_err  = 1'b0;
      end
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ErrClr) begin
      err_cnt_d = '0;
    end else if (out_xfer && s2_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      s1_inst_q  <= '0;
      s1_imm_q   <= '0;
      s1_ctrl_q  <= FieldI;
    end else if (InReady) begin
      s1_valid_q <= InValid;
      if (InValid) begin
        s1_inst_q <= InInst;
        s1_imm_q  <= InImm;
        s1_ctrl_q <= field_e'(InCtrl);
      end
    end
  end

  // Result data only changes when a new result enters, so it holds during output stalls.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_err_q   <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_inst_q <= pack_inst;
        s2_err_q  <= pack_err;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
